// File: rtl/wave_seq_pkg.sv
// Shared encodings and geometry for the wave-arena phase sequencer.
package wave_seq_pkg;

  localparam int unsigned PERIOD  = 400;
  localparam int unsigned X_W     = 10;
  localparam int unsigned SPEED_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_INTRO    = 3'd1,
    PH_RAMP     = 3'd2,
    PH_HOLD     = 3'd3,
    PH_REVERSE  = 3'd4,
    PH_GAMEOVER = 3'd5
  } phase_e;

  function automatic logic is_active(input phase_e p);
    return p inside {PH_INTRO, PH_RAMP, PH_HOLD, PH_REVERSE};
  endfunction

endpackage

// File: rtl/wave_phase_sequencer_offset_stepper.sv
// Wrapped scroll step: x' = (x +/- s) mod PERIOD, valid because s < PERIOD.
module offset_stepper
  import wave_seq_pkg::*;
(
  input  logic [X_W-1:0]     x_i,
  input  logic [SPEED_W-1:0] s_i,
  input  logic               dir_i,
  output logic [X_W-1:0]     x_o
);

  localparam logic [X_W:0] PERIOD_W = (X_W+1)'(PERIOD);

  logic [X_W:0] s_ext;
  logic [X_W:0] sum;

  assign s_ext = {{(X_W+1-SPEED_W){1'b0}}, s_i};

  always_comb begin
    if (dir_i) sum = {1'b0, x_i} + PERIOD_W - s_ext;
    else       sum = {1'b0, x_i} + s_ext;
    if (sum >= PERIOD_W) sum = sum - PERIOD_W;
  end

  assign x_o = sum[X_W-1:0];

endmodule

// File: rtl/wave_phase_sequencer.sv
// Frame-rate phase sequencer: attack phases, wrapped scroll offset, player HP.
module wave_phase_sequencer
  import wave_seq_pkg::*;
#(
  parameter int unsigned INTRO_FRAMES = 60,
  parameter int unsigned RAMP_FRAMES  = 30,
  parameter int unsigned HOLD_FRAMES  = 120,
  parameter int unsigned MAX_SPEED    = 8,
  parameter int unsigned HP_INIT      = 92,
  parameter int unsigned HIT_DAMAGE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       manual,
  input  logic [3:0] ui_speed,
  input  logic       ui_dir,
  input  logic       hit,
  output logic [9:0] x_offset,
  output logic       scroll_dir,
  output logic [3:0] speed,
  output logic [2:0] phase,
  output logic       show_player,
  output logic [7:0] hp,
  output logic       game_over
);

  localparam logic [SPEED_W-1:0] MAX_SPD    = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] MIN_SPD    = SPEED_W'(1);
  localparam logic [CNT_W-1:0]   INTRO_LAST = CNT_W'(INTRO_FRAMES - 1);
  localparam logic [CNT_W-1:0]   RAMP_LAST  = CNT_W'(RAMP_FRAMES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [7:0]         HP_START   = 8'(HP_INIT);
  localparam logic [7:0]         DAMAGE     = 8'(HIT_DAMAGE);

  phase_e             phase_q;
  logic [X_W-1:0]     x_q;
  logic               dir_q;
  logic [SPEED_W-1:0] speed_q;
  logic [SPEED_W-1:0] ramp_spd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         hp_q;
  logic               hit_q;

  logic [X_W-1:0]     x_d;
  logic [7:0]         hp_d;
  logic [SPEED_W-1:0] step_spd;
  logic               step_dir;
  logic               hit_now;
  logic               start_ok;

  // Step source: UI values in manual mode, otherwise the phase's own speed/dir,
  // so releasing manual restores the auto values on the next tick.
  always_comb begin
    step_spd = ramp_spd_q;
    step_dir = 1'b0;
    if (manual) begin
      step_spd = (ui_speed == '0) ? MIN_SPD : ui_speed;
      step_dir = ui_dir;
    end else begin
      case (phase_q)
        PH_HOLD:    step_spd = MAX_SPD;
        PH_REVERSE: begin
          step_spd = MAX_SPD;
          step_dir = 1'b1;
        end
        default: ;
      endcase
    end
  end

  offset_stepper u_step (
    .x_i   (x_q),
    .s_i   (step_spd),
    .dir_i (step_dir),
    .x_o   (x_d)
  );

  assign hit_now  = hit_q | hit;
  assign hp_d     = (hp_q > DAMAGE) ? (hp_q - DAMAGE) : '0;
  assign start_ok = start && (phase_q == PH_IDLE || phase_q == PH_GAMEOVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_IDLE;
      x_q        <= '0;
      dir_q      <= 1'b0;
      speed_q    <= MIN_SPD;
      ramp_spd_q <= MIN_SPD;
      cnt_q      <= '0;
      hp_q       <= HP_START;
      hit_q      <= 1'b0;
    end else if (start_ok) begin
      phase_q    <= PH_INTRO;
      x_q        <= '0;
      dir_q      <= 1'b0;
      speed_q    <= MIN_SPD;
      ramp_spd_q <= MIN_SPD;
      cnt_q      <= '0;
      hp_q       <= HP_START;
      hit_q      <= 1'b0;
    end else begin
      if (is_active(phase_q) && hit) hit_q <= 1'b1;
      if (frame_tick && is_active(phase_q)) begin
        hit_q <= 1'b0;
        if (hit_now) hp_q <= hp_d;
        if (hit_now && hp_d == '0) begin
          phase_q <= PH_GAMEOVER;
          cnt_q   <= '0;
        end else if (manual) begin
          x_q     <= x_d;
          speed_q <= step_spd;
          dir_q   <= step_dir;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          case (phase_q)
            PH_INTRO: begin
              speed_q <= MIN_SPD;
              dir_q   <= 1'b0;
              if (cnt_q == INTRO_LAST) begin
                phase_q    <= PH_RAMP;
                cnt_q      <= '0;
                ramp_spd_q <= MIN_SPD;
              end
            end
            PH_RAMP: begin
              x_q     <= x_d;
              dir_q   <= 1'b0;
              speed_q <= ramp_spd_q;
              if (cnt_q == RAMP_LAST) begin
                cnt_q <= '0;
                if (ramp_spd_q == MAX_SPD) begin
                  phase_q <= PH_HOLD;
                end else begin
                  ramp_spd_q <= ramp_spd_q + 1'b1;
                  speed_q    <= ramp_spd_q + 1'b1;
                end
              end
            end
            PH_HOLD: begin
              x_q     <= x_d;
              speed_q <= MAX_SPD;
              dir_q   <= 1'b0;
              if (cnt_q == HOLD_LAST) begin
                phase_q <= PH_REVERSE;
                dir_q   <= 1'b1;
                cnt_q   <= '0;
              end
            end
            PH_REVERSE: begin
              x_q     <= x_d;
              speed_q <= MAX_SPD;
              dir_q   <= 1'b1;
              if (cnt_q == HOLD_LAST) begin
                phase_q    <= PH_RAMP;
                dir_q      <= 1'b0;
                speed_q    <= MIN_SPD;
                ramp_spd_q <= MIN_SPD;
                cnt_q      <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign x_offset    = x_q;
  assign scroll_dir  = dir_q;
  assign speed       = speed_q;
  assign phase       = phase_q;
  assign show_player = is_active(phase_q);
  assign hp          = hp_q;
  assign game_over   = (phase_q == PH_GAMEOVER);

endmodule

// File: tb/tb_wave_phase_sequencer.sv
// Directed bench for wave_phase_sequencer with a behavioural model feeding a scoreboard.
module tb_wave_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, start, manual, ui_dir, hit;
  logic [3:0] ui_speed;
  logic [9:0] x_offset;
  logic       scroll_dir, show_player, game_over;
  logic [3:0] speed;
  logic [2:0] phase;
  logic [7:0] hp;

  logic [9:0] t_x, t_y;
  logic [3:0] t_s;
  logic       t_dir;

  int n_pass = 0;
  int n_total = 0;

  wave_phase_sequencer #(
    .INTRO_FRAMES (60),
    .RAMP_FRAMES  (30),
    .HOLD_FRAMES  (120),
    .MAX_SPEED    (8),
    .HP_INIT      (92),
    .HIT_DAMAGE   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .start       (start),
    .manual      (manual),
    .ui_speed    (ui_speed),
    .ui_dir      (ui_dir),
    .hit         (hit),
    .x_offset    (x_offset),
    .scroll_dir  (scroll_dir),
    .speed       (speed),
    .phase       (phase),
    .show_player (show_player),
    .hp          (hp),
    .game_over   (game_over)
  );

  offset_stepper u_wrap (
    .x_i   (t_x),
    .s_i   (t_s),
    .dir_i (t_dir),
    .x_o   (t_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int dir; int spd; int ph; int show; int hp; int go;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int m_x, m_dir, m_spd, m_ramp, m_ph, m_cnt, m_hp, m_latch;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_x = 0; m_dir = 0; m_spd = 1; m_ramp = 1; m_ph = 0; m_cnt = 0; m_hp = 92; m_latch = 0;
  endtask

  task automatic model(input bit st, input bit tk, input bit ht);
    int s;
    bit act;
    act = (m_ph >= 1 && m_ph <= 4);
    if (st && !act) begin
      m_ph = 1; m_hp = 92; m_x = 0; m_spd = 1; m_dir = 0; m_cnt = 0; m_latch = 0; m_ramp = 1;
      return;
    end
    if (act && ht) m_latch = 1;
    if (!(tk && act)) return;
    if (m_latch == 1) begin
      m_latch = 0;
      m_hp = (m_hp > 1) ? m_hp - 1 : 0;
      if (m_hp == 0) begin
        m_ph = 5; m_cnt = 0;
        return;
      end
    end
    if (manual) begin
      s = (ui_speed == 0) ? 1 : int'(ui_speed);
      m_spd = s; m_dir = int'(ui_dir);
      m_x = ui_dir ? (m_x + 400 - s) % 400 : (m_x + s) % 400;
      return;
    end
    m_cnt++;
    case (m_ph)
      1: begin
        m_spd = 1; m_dir = 0;
        if (m_cnt == 60) begin m_ph = 2; m_cnt = 0; m_ramp = 1; end
      end
      2: begin
        m_x = (m_x + m_ramp) % 400; m_dir = 0;
        if (m_cnt == 30) begin
          m_cnt = 0;
          if (m_ramp == 8) m_ph = 3; else m_ramp++;
        end
        m_spd = m_ramp;
      end
      3: begin
        m_x = (m_x + 8) % 400; m_spd = 8; m_dir = 0;
        if (m_cnt == 120) begin m_ph = 4; m_dir = 1; m_cnt = 0; end
      end
      4: begin
        m_x = (m_x + 392) % 400; m_spd = 8; m_dir = 1;
        if (m_cnt == 120) begin m_ph = 2; m_dir = 0; m_spd = 1; m_ramp = 1; m_cnt = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit st, input bit tk, input bit ht);
    exp_t e;
    @(negedge clk);
    start = st; frame_tick = tk; hit = ht;
    model(st, tk, ht);
    e.x = m_x; e.dir = m_dir; e.spd = m_spd; e.ph = m_ph; e.hp = m_hp;
    e.show = (m_ph >= 1 && m_ph <= 4) ? 1 : 0;
    e.go = (m_ph == 5) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    e = sb.pop_front();
    check("x_offset",    16'(x_offset),    16'(e.x));
    check("scroll_dir",  16'(scroll_dir),  16'(e.dir));
    check("speed",       16'(speed),       16'(e.spd));
    check("phase",       16'(phase),       16'(e.ph));
    check("show_player", 16'(show_player), 16'(e.show));
    check("hp",          16'(hp),          16'(e.hp));
    check("game_over",   16'(game_over),   16'(e.go));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},     16'(x_offset),    16'd0);
    check({tag, "_dir"},   16'(scroll_dir),  16'd0);
    check({tag, "_speed"}, 16'(speed),       16'd1);
    check({tag, "_phase"}, 16'(phase),       16'd0);
    check({tag, "_show"},  16'(show_player), 16'd0);
    check({tag, "_hp"},    16'(hp),          16'd92);
    check({tag, "_go"},    16'(game_over),   16'd0);
  endtask

  initial begin
    int x0;
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; manual = 1'b0;
    ui_speed = 4'd0; ui_dir = 1'b0; hit = 1'b0;
    model_reset();

    // Wrap boundaries of the stepper
    t_x = 10'd398; t_s = 4'd4; t_dir = 1'b0; #1 check("wrap_fwd_398_4", 16'(t_y), 16'd2);
    t_x = 10'd2;   t_s = 4'd4; t_dir = 1'b1; #1 check("wrap_rev_2_4",   16'(t_y), 16'd398);
    t_x = 10'd0;   t_s = 4'd1; t_dir = 1'b1; #1 check("wrap_rev_0_1",   16'(t_y), 16'd399);
    t_x = 10'd399; t_s = 4'd1; t_dir = 1'b0; #1 check("wrap_fwd_399_1", 16'(t_y), 16'd0);
    t_x = 10'd100; t_s = 4'd15; t_dir = 1'b0; #1 check("step_fwd_100_15", 16'(t_y), 16'd115);

    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;

    // Start and INTRO
    step(1'b1, 1'b0, 1'b0);
    check("start_phase", 16'(phase), 16'd1);
    check("start_hp",    16'(hp),    16'd92);
    ticks(59);
    check("intro_x_still", 16'(x_offset), 16'd0);
    check("intro_phase_59", 16'(phase), 16'd1);
    ticks(1);
    check("intro_done_phase", 16'(phase), 16'd2);
    check("intro_done_speed", 16'(speed), 16'd1);

    // start in RAMP is ignored
    step(1'b1, 1'b0, 1'b0);
    check("start_in_ramp", 16'(phase), 16'd2);

    // RAMP with a few idle cycles between ticks
    for (int i = 0; i < 210; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i % 50 == 0) step(1'b0, 1'b0, 1'b0);
    end
    check("ramp_speed_max", 16'(speed), 16'd8);
    check("ramp_phase_still", 16'(phase), 16'd2);
    ticks(29);
    check("ramp_last_phase", 16'(phase), 16'd2);
    ticks(1);
    check("hold_entered", 16'(phase), 16'd3);
    ticks(119);
    check("hold_last_phase", 16'(phase), 16'd3);
    ticks(1);
    check("reverse_entered", 16'(phase), 16'd4);
    check("reverse_dir", 16'(scroll_dir), 16'd1);

    // Hits: burst counts once; hit on the tick cycle counts
    repeat (5) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("hit_burst_once", 16'(hp), 16'd91);
    step(1'b0, 1'b1, 1'b1);
    check("hit_on_tick", 16'(hp), 16'd90);

    // Manual: speed 0 treated as 1, reverse; phase frozen
    x0 = m_x;
    manual = 1'b1; ui_speed = 4'd0; ui_dir = 1'b1;
    ticks(5);
    check("manual_x", 16'(x_offset), 16'((x0 + 400 - 5) % 400));
    check("manual_speed", 16'(speed), 16'd1);
    check("manual_phase", 16'(phase), 16'd4);
    ui_speed = 4'd13; ui_dir = 1'b0;
    ticks(3);
    manual = 1'b0; ui_speed = 4'd0; ui_dir = 1'b0;
    ticks(1);
    check("release_speed", 16'(speed), 16'd8);
    check("release_dir", 16'(scroll_dir), 16'd1);
    ticks(116);
    check("reverse_last_phase", 16'(phase), 16'd4);
    ticks(1);
    check("reverse_to_ramp", 16'(phase), 16'd2);
    check("reverse_to_ramp_speed", 16'(speed), 16'd1);
    check("reverse_to_ramp_dir", 16'(scroll_dir), 16'd0);

    // Drain HP to game over
    while (m_hp > 1) step(1'b0, 1'b1, 1'b1);
    check("hp_one", 16'(hp), 16'd1);
    x0 = m_x;
    step(1'b0, 1'b1, 1'b1);
    check("gameover_phase", 16'(phase), 16'd5);
    check("gameover_show", 16'(show_player), 16'd0);
    check("gameover_hp", 16'(hp), 16'd0);
    check("gameover_x_frozen", 16'(x_offset), 16'(x0));
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("gameover_hp_hold", 16'(hp), 16'd0);

    // start + tick in GAMEOVER: start wins, counter starts at 0
    step(1'b1, 1'b1, 1'b0);
    check("restart_phase", 16'(phase), 16'd1);
    check("restart_hp", 16'(hp), 16'd92);
    ticks(59);
    check("restart_intro_59", 16'(phase), 16'd1);
    ticks(1);
    check("restart_ramp", 16'(phase), 16'd2);
    ticks(240);
    check("restart_hold", 16'(phase), 16'd3);
    ticks(10);

    // Asynchronous reset mid-HOLD
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midhold_reset");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    check("post_reset_idle", 16'(phase), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
